// File: rtl/pipe_reg_hs.sv
// Elastic pipeline register with valid/ready handshake on both sides.
// Optional skid entry keeps in_ready flop-driven; flush injects a bubble.
module pipe_reg_hs #(
    parameter int            DW      = 32,
    parameter bit            SKID    = 1'b1,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic [DW-1:0] set_data,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    occ_o
);

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          s_valid;
    logic          in_fire;
    logic          out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occ_o     = {1'b0, m_valid} + {1'b0, s_valid};

    if (SKID) begin : g_skid
        logic [DW-1:0] s_data;
        logic          rdy_q;

        // rdy_q always mirrors !s_valid, but comes straight from a flop
        assign in_ready = rdy_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_valid <= 1'b0;
                m_data  <= RST_VAL;
                s_valid <= 1'b0;
                s_data  <= '0;
                rdy_q   <= 1'b1;
            end else if (flush_i) begin
                m_valid <= 1'b0;
                m_data  <= set_data;
                s_valid <= 1'b0;
                rdy_q   <= 1'b1;
            end else if (!m_valid || out_fire) begin
                if (s_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= s_data;
                    s_valid <= 1'b0;
                    rdy_q   <= 1'b1;
                end else if (in_fire) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (in_fire) begin
                s_valid <= 1'b1;
                s_data  <= in_data;
                rdy_q   <= 1'b0;
            end
        end
    end else begin : g_single
        assign s_valid  = 1'b0;
        assign in_ready = !m_valid | out_ready;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_valid <= 1'b0;
                m_data  <= RST_VAL;
            end else if (flush_i) begin
                m_valid <= 1'b0;
                m_data  <= set_data;
            end else if (in_fire) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
            end else if (out_fire) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Directed bench for pipe_reg_hs: skid (32-bit) and single-entry (8-bit)
// instances sharing clock and reset.
module tb_pipe_reg_hs;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] set_data;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  occ_o;

    logic        flush2;
    logic [7:0]  set_data2;
    logic        in_valid2;
    logic [7:0]  in_data2;
    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic        out_ready2;
    logic [1:0]  occ2;

    int checks;
    int failures;

    pipe_reg_hs #(
        .DW(32), .SKID(1'b1), .RST_VAL(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .set_data(set_data), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .occ_o(occ_o)
    );

    pipe_reg_hs #(
        .DW(8), .SKID(1'b0), .RST_VAL(8'h5A)
    ) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush2),
        .set_data(set_data2), .in_valid(in_valid2),
        .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready2), .occ_o(occ2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        flush_i    = 1'b0;
        set_data   = 32'h0;
        in_valid   = 1'b1;
        in_data    = 32'h99;
        out_ready  = 1'b0;
        flush2     = 1'b0;
        set_data2  = 8'h0;
        in_valid2  = 1'b1;
        in_data2   = 8'h77;
        out_ready2 = 1'b0;

        // reset held with traffic offered
        tick(); tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_occ", occ_o, 0);
        chk("rst_valid0", out_valid2, 0);
        chk("rst_data0", out_data2, 8'h5A);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_ready0", in_ready2, 1);

        // streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        chk("st_v1", out_valid, 1);
        chk("st_d1", out_data, 32'h11);
        chk("st_o1", occ_o, 1);
        in_data = 32'h22;
        tick();
        chk("st_d2", out_data, 32'h22);
        chk("st_o2", occ_o, 1);
        in_data = 32'h33;
        tick();
        chk("st_d3", out_data, 32'h33);
        chk("st_o3", occ_o, 1);
        in_valid = 1'b0;
        tick();
        chk("st_empty", out_valid, 0);
        chk("st_hold", out_data, 32'h33);

        // backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        chk("bp_occ1", occ_o, 1);
        chk("bp_rdy1", in_ready, 1);
        in_data = 32'hB;
        tick();
        chk("bp_dA", out_data, 32'hA);
        chk("bp_occ2", occ_o, 2);
        chk("bp_rdy0", in_ready, 0);
        in_data = 32'hC;
        tick();
        chk("bp_stall_d", out_data, 32'hA);
        chk("bp_stall_v", out_valid, 1);
        chk("bp_stall_o", occ_o, 2);
        out_ready = 1'b1;
        tick();
        chk("bp_dB", out_data, 32'hB);
        chk("bp_oB", occ_o, 1);
        chk("bp_rdyB", in_ready, 1);
        tick();
        chk("bp_dC", out_data, 32'hC);
        chk("bp_vC", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_end", out_valid, 0);

        // flush with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        chk("fl_occ2", occ_o, 2);
        flush_i  = 1'b1;
        set_data = 32'h13;
        in_data  = 32'h3;
        tick();
        chk("fl_v", out_valid, 0);
        chk("fl_d", out_data, 32'h13);
        chk("fl_o", occ_o, 0);
        chk("fl_r", in_ready, 1);
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_drop", out_valid, 0);
        chk("fl_keep", out_data, 32'h13);

        // single-entry instance
        in_valid2  = 1'b1;
        in_data2   = 8'h5;
        out_ready2 = 1'b1;
        #1;
        chk("s0_r1", in_ready2, 1);
        tick();
        chk("s0_v5", out_valid2, 1);
        chk("s0_d5", out_data2, 8'h5);
        chk("s0_o5", occ2, 1);
        out_ready2 = 1'b0;
        in_data2   = 8'h6;
        #1;
        chk("s0_r0", in_ready2, 0);
        tick();
        chk("s0_hold", out_data2, 8'h5);
        chk("s0_ohold", occ2, 1);
        out_ready2 = 1'b1;
        #1;
        chk("s0_r2", in_ready2, 1);
        tick();
        chk("s0_d6", out_data2, 8'h6);
        chk("s0_v6", out_valid2, 1);
        in_valid2 = 1'b0;
        tick();
        chk("s0_end", out_valid2, 0);
        chk("s0_last", out_data2, 8'h6);

        // async reset with occ=2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h44;
        tick();
        in_data = 32'h55;
        tick();
        chk("ar_occ2", occ_o, 2);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_v", out_valid, 0);
        chk("ar_o", occ_o, 0);
        chk("ar_d", out_data, 32'h0);
        chk("ar_d0", out_data2, 8'h5A);
        #2;
        rst = 1'b1;
        tick();
        chk("ar_r", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
